// File: rtl/i2s_stream_pkg.sv
// Shared constants, header layout, FSM encoding and header packing for the I2S row streamer.
package i2s_stream_pkg;

   localparam int HDR_W       = 16;
   localparam int WORD_W      = 16;
   localparam int ROW_W       = 6;
   localparam int IDX_W       = 8;
   localparam int HDR_X_LSB   = 12;
   localparam int HDR_Y_LSB   = 8;
   localparam int HDR_ROW_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } st_e;

   typedef struct packed {
      logic [3:0] mod_x_m1;
      logic [3:0] mod_y_m1;
   } cfg_t;

   // Bits [7:6] are reserved and always sent as zero.
   function automatic logic [HDR_W-1:0] hdr_pack(input cfg_t c, input logic [ROW_W-1:0] row);
      logic [HDR_W-1:0] h;
      h = '0;
      h[HDR_X_LSB +: 4]       = c.mod_x_m1;
      h[HDR_Y_LSB +: 4]       = c.mod_y_m1;
      h[HDR_ROW_LSB +: ROW_W] = row;
      return h;
   endfunction

endpackage

// File: rtl/i2s_bit_shifter.sv
// 16-bit parallel-load, left-shift register; the MSB is the serial output bit.
module i2s_bit_shifter
   import i2s_stream_pkg::*;
(
   input  logic              i2s_clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] din,
   output logic              msb
);

   logic [WORD_W-1:0] sr;

   always_ff @(posedge i2s_clk or negedge rst_n) begin
      if (!rst_n)     sr <= '0;
      else if (load)  sr <= din;
      else if (shift) sr <= {sr[WORD_W-2:0], 1'b0};
   end

   assign msb = sr[WORD_W-1];

endmodule

// File: rtl/i2s_frame_streamer.sv
// Row-packet serializer: header + W payload words per row, with one-word prefetch from the frame buffer.
// Optional build macro I2S_STREAMER_TESTPAT_EN adds test_mode, which replaces fetched words with a pattern.
module i2s_frame_streamer
   import i2s_stream_pkg::*;
#(
   parameter int NUM_ROWS = 32,
   parameter int ADDR_W   = 14
) (
   input  logic              i2s_clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [3:0]        cfg_mod_x_m1,
   input  logic [3:0]        cfg_mod_y_m1,
`ifdef I2S_STREAMER_TESTPAT_EN
   input  logic              test_mode,
`endif
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [WORD_W-1:0] rd_data,
   output logic              i2s_data,
   output logic              bit_valid,
   output logic              row_start,
   output logic              frame_done,
   output logic              busy
);

   st_e               state, state_nxt;
   cfg_t              cfg_q, cfg_in;
   logic [ROW_W-1:0]  row_q, row_inc;
   logic [11:0]       bit_cnt;
   logic [8:0]        words;
   logic [12:0]       pay_bits;
   logic [8:0]        nxt_idx;
   logic              word_end, last_pay, tpat_q;
   logic              start_row, row_adv, sh_load, sh_shift, sh_msb;
   logic [WORD_W-1:0] sh_din, pay_word;

   assign cfg_in   = '{mod_x_m1: cfg_mod_x_m1, mod_y_m1: cfg_mod_y_m1};
   assign words    = ({5'd0, cfg_q.mod_x_m1} + 9'd1) * ({5'd0, cfg_q.mod_y_m1} + 9'd1);
   assign pay_bits = {words, 4'h0};
   assign word_end = (bit_cnt[3:0] == 4'hF);
   assign last_pay = (state == ST_PAYLOAD) && (bit_cnt == 12'(pay_bits - 13'd1));
   assign row_inc  = (row_q == ROW_W'(NUM_ROWS - 1)) ? '0 : row_q + 1'b1;
   // Index of the word that follows the one currently on the wire.
   assign nxt_idx  = (state == ST_HEADER) ? 9'd0 : {1'b0, bit_cnt[11:4]} + 9'd1;
   assign pay_word = tpat_q ? {row_q, nxt_idx[IDX_W-1:0], 2'b01} : rd_data;

   always_ff @(posedge i2s_clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_row = 1'b0;
      row_adv   = 1'b0;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
      sh_din    = '0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               state_nxt = ST_HEADER;
               start_row = 1'b1;
               sh_load   = 1'b1;
               sh_din    = hdr_pack(cfg_in, row_q);
            end
         end
         ST_HEADER: begin
            if (word_end) begin
               state_nxt = ST_PAYLOAD;
               sh_load   = 1'b1;
               sh_din    = pay_word;
            end else begin
               sh_shift  = 1'b1;
            end
         end
         ST_PAYLOAD: begin
            if (last_pay) begin
               row_adv = 1'b1;
               sh_load = 1'b1;
               if (enable) begin
                  state_nxt = ST_HEADER;
                  start_row = 1'b1;
                  sh_din    = hdr_pack(cfg_in, row_inc);
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else if (word_end) begin
               sh_load = 1'b1;
               sh_din  = pay_word;
            end else begin
               sh_shift = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Bit counter restarts on every phase change; in IDLE it rests at zero.
   always_ff @(posedge i2s_clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         row_q   <= '0;
         cfg_q   <= '0;
      end else begin
         if (state_nxt != state)     bit_cnt <= '0;
         else if (state != ST_IDLE)  bit_cnt <= bit_cnt + 12'd1;
         if (row_adv)   row_q <= row_inc;
         if (start_row) cfg_q <= cfg_in;
      end
   end

`ifdef I2S_STREAMER_TESTPAT_EN
   always_ff @(posedge i2s_clk or negedge rst_n) begin
      if (!rst_n)         tpat_q <= 1'b0;
      else if (start_row) tpat_q <= test_mode;
   end
`else
   assign tpat_q = 1'b0;
`endif

   i2s_bit_shifter u_shifter (
      .i2s_clk (i2s_clk),
      .rst_n   (rst_n),
      .load    (sh_load),
      .shift   (sh_shift),
      .din     (sh_din),
      .msb     (sh_msb)
   );

   // Shifter is loaded with zero on the way to IDLE, so its MSB is already gated.
   assign i2s_data   = sh_msb;
   assign busy       = (state != ST_IDLE);
   assign bit_valid  = busy;
   assign row_start  = (state == ST_HEADER) && (bit_cnt == 12'd0);
   assign frame_done = last_pay && (row_q == ROW_W'(NUM_ROWS - 1));
   assign rd_en      = busy && !tpat_q && (bit_cnt[3:0] == 4'hE) && (nxt_idx < words);
   assign rd_addr    = rd_en ? ADDR_W'({row_q, nxt_idx[IDX_W-1:0]}) : '0;

endmodule
